// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum support is selected with IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef logic [1:0] lane_t;

  // States in which the loader is consuming the byte stream.
  function automatic logic accepts_bytes(state_e s);
    return (s == S_HDR) || (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects bytes little-endian into a 32-bit word; word_valid pulses for
// one cycle after the fourth byte of a word has been pushed.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  lane
);

  lane_t       lane_q;
  logic [31:0] word_q;
  logic        valid_q;

  // The lane index wraps naturally from 3 back to 0 at each word boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= push && (lane_q == 2'd3);
      if (clear) begin
        lane_q <= '0;
      end else if (push) begin
        word_q[{lane_q, 3'b000} +: 8] <= byte_in;
        lane_q                        <= lane_q + 2'd1;
      end
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign lane       = lane_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-serial boot loader filling instruction memory and holding the core in
// reset until an image is in place. IMEM_LOADER_CSUM_EN adds the XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic              done_q;
  logic              error_q;
  logic              cpu_rst_n_q;
  logic [7:0]        len_q;
  logic [7:0]        wcnt_q;
  logic [ADDR_W-1:0] addr_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        xor_q;
`endif

  logic        accept;
  logic        len_ok;
  logic        push;
  logic        clear;
  logic        last_lane;
  logic        last_word;
  logic [1:0]  lane;
  logic [31:0] packed_word;
  logic        packed_valid;

  assign accept    = in_valid & in_ready_q;
  assign len_ok    = (in_byte != 8'd0) && (in_byte <= DEPTH_B);
  assign push      = accept && (state_q == S_DATA);
  assign clear     = accept && (state_q == S_LEN) && len_ok;
  assign last_lane = (lane == 2'd3);
  assign last_word = (wcnt_q == (len_q - 8'd1));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (push),
    .byte_in    (in_byte),
    .word       (packed_word),
    .word_valid (packed_valid),
    .lane       (lane)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept && (in_byte == HDR_BYTE)) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) state_d = len_ok ? S_DATA : S_ERR;
      end
      S_DATA: begin
        if (push && last_lane && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) state_d = (in_byte == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are derived from the next state so they change on the
  // same edge that moves the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      len_q       <= '0;
      wcnt_q      <= '0;
      addr_q      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= accepts_bytes(state_d);
      done_q      <= (state_d == S_DONE);
      cpu_rst_n_q <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERR);
      if (clear) begin
        len_q  <= in_byte;
        wcnt_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        xor_q  <= '0;
`endif
      end
      if (push) begin
`ifdef IMEM_LOADER_CSUM_EN
        xor_q <= xor_q ^ in_byte;
`endif
        if (last_lane) begin
          addr_q <= ADDR_W'(wcnt_q);
          wcnt_q <= wcnt_q + 8'd1;
        end
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = packed_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = packed_word;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized data
// and stalls, checked against a frame-level reference model.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              error;

  int compareCount = 0;
  int failCount    = 0;

  logic [39:0] obsWrites[$];
  logic [39:0] expWrites[$];
  logic [7:0]  frame[$];
  logic        expDone;
  logic        expErr;
  logic        lastWeDone = 1'b0;

  imem_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Every memory write is logged away from the active edge.
  always @(negedge clk) begin
    if (imem_we) begin
      obsWrites.push_back({8'(imem_addr), imem_wdata});
      lastWeDone = done;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: interprets the whole frame from the framing rules.
  task automatic modelFrame();
    int          h;
    int          n;
    logic [31:0] w;
    logic [7:0]  x;
    expWrites.delete();
    expDone = 1'b0;
    expErr  = 1'b0;
    h = 0;
    while (h < frame.size() && frame[h] != 8'hA5) h++;
    if (h + 1 >= frame.size()) return;
    n = int'(frame[h+1]);
    if (n == 0 || n > DEPTH) begin
      expErr = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        w = w | (32'(frame[h + 2 + 4*k + j]) << (8*j));
        x = x ^ frame[h + 2 + 4*k + j];
      end
      expWrites.push_back({8'(k), w});
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (frame[h + 2 + 4*n] == x) expDone = 1'b1;
    else expErr = 1'b1;
`else
    expDone = 1'b1;
`endif
  endtask

  task automatic makeFrame(input logic [31:0] words[$], input bit badCsum);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    frame.push_back(8'hA5);
    frame.push_back(8'(words.size()));
    foreach (words[k]) begin
      for (int j = 0; j < 4; j++) begin
        b = words[k][8*j +: 8];
        frame.push_back(b);
        x = x ^ b;
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    frame.push_back(badCsum ? (x ^ 8'h01) : x);
`else
    if (badCsum) x = ~x;
`endif
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapPct);
    int guard;
    while ($urandom_range(99) < gapPct) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte  = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("accept_timeout", 64'(guard), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int gapPct, input int count);
    for (int i = 0; i < count && i < frame.size(); i++) sendByte(frame[i], gapPct);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkWrites(input string name);
    checkOutput({name, " write_count"}, 64'(obsWrites.size()), 64'(expWrites.size()));
    for (int i = 0; i < obsWrites.size() && i < expWrites.size(); i++) begin
      checkOutput($sformatf("%s write%0d_addr", name, i), 64'(obsWrites[i][39:32]), 64'(expWrites[i][39:32]));
      checkOutput($sformatf("%s write%0d_data", name, i), 64'(obsWrites[i][31:0]), 64'(expWrites[i][31:0]));
    end
  endtask

  task automatic runFrame(input string name, input int gapPct, input bit doStart);
    obsWrites.delete();
    if (doStart) pulseStart();
    modelFrame();
    applyStimulus(gapPct, frame.size());
    repeat (2) @(negedge clk);
    checkWrites(name);
    checkOutput({name, " done"}, 64'(done), 64'(expDone));
    checkOutput({name, " error"}, 64'(error), 64'(expErr));
    checkOutput({name, " cpu_rst_n"}, 64'(cpu_rst_n), 64'(expDone));
    checkOutput({name, " in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({name, " imem_we"}, 64'(imem_we), 64'd0);
    checkOutput({name, " imem_addr"}, 64'(imem_addr), 64'd0);
    checkOutput({name, " imem_wdata"}, 64'(imem_wdata), 64'd0);
    checkOutput({name, " cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    checkOutput({name, " done"}, 64'(done), 64'd0);
    checkOutput({name, " error"}, 64'(error), 64'd0);
  endtask

  initial begin
    logic [31:0] words[$];
    int          n;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    @(negedge clk);

    // Nominal two-word image, back-to-back bytes.
    words = '{32'h0000_0000, 32'h0042_D663};
    frame.delete();
    makeFrame(words, 1'b0);
    runFrame("nominal", 0, 1'b1);
`ifdef IMEM_LOADER_CSUM_EN
    checkOutput("nominal done_at_last_we", 64'(lastWeDone), 64'd0);
`else
    checkOutput("nominal done_at_last_we", 64'(lastWeDone), 64'd1);
`endif

    // Reload from DONE: core reset reasserts with in_ready rising.
    pulseStart();
    checkOutput("reload cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    checkOutput("reload done", 64'(done), 64'd0);
    checkOutput("reload in_ready", 64'(in_ready), 64'd1);
    words = '{32'($urandom)};
    frame.delete();
    makeFrame(words, 1'b0);
    runFrame("reload", 20, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
    words = '{32'h0000_0000, 32'h0042_D663};
    frame.delete();
    makeFrame(words, 1'b1);
    runFrame("badcsum", 0, 1'b1);
`endif

    frame = '{8'hA5, 8'h00};
    runFrame("len0", 0, 1'b1);
    frame = '{8'hA5, 8'h21};
    runFrame("len33", 0, 1'b1);

    words.delete();
    for (int i = 0; i < 32; i++) words.push_back(32'($urandom));
    frame.delete();
    makeFrame(words, 1'b0);
    runFrame("len32", 0, 1'b1);

    // Header hunt with garbage preamble and random stalls.
    words = '{32'h0000_0000, 32'h0042_D663};
    frame = '{8'h00, 8'hFF, 8'h5A};
    makeFrame(words, 1'b0);
    runFrame("hunt", 40, 1'b1);

    // Reset after six data bytes: one word already written, nothing after.
    words = '{32'h1122_3344, 32'h5566_7788};
    frame.delete();
    makeFrame(words, 1'b0);
    obsWrites.delete();
    pulseStart();
    applyStimulus(0, 8);
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("midreset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset write_count", 64'(obsWrites.size()), 64'd1);
    checkOutput("midreset write0_data", 64'(obsWrites.size() > 0 ? obsWrites[0][31:0] : 32'h0), 64'h1122_3344);
    runFrame("postreset", 0, 1'b1);

    // Randomized images with stalls and random garbage before the header.
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(8, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(32'($urandom));
      frame.delete();
      for (int g = $urandom_range(3, 0); g > 0; g--) frame.push_back(8'($urandom_range(8'hA4, 0)));
      makeFrame(words, ($urandom_range(3, 0) == 0));
      runFrame($sformatf("random%0d", t), 30, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that fills the core's instruction memory from a byte-serial stream before execution starts. It accepts one framed program image over a valid/ready byte interface and assembles little-endian 32-bit words. Each word goes out on a single-cycle write port into the instruction memory array that `fetch` reads. While loading, the block holds the core in reset through `cpu_rst_n`, and releases it only after a valid image has been written.

## Interface
- `DEPTH`, 32: instruction memory size in words; legal range 1..255.
- `ADDR_W`, 5: word address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low. Clock is `clk`.
- `start`  in  1  level/pulse; begins a load from IDLE, DONE or ERR.
- `in_valid`  in  1  byte present on `in_byte`.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  word to write.
- `cpu_rst_n`  out  1  core reset, active-low; low holds the core in reset.
- `done`  out  1  image loaded and accepted.
- `error`  out  1  frame rejected.

## Operation
- Frame format: header 0xA5, then length N (words), then 4·N data bytes (little-endian, first byte → [7:0]), then checksum (XOR of all data bytes).
- A byte is accepted on a rising edge with `in_valid & in_ready`. When `in_ready` is low, the byte is not consumed.
- States and transitions:
  - IDLE: `start` → HDR.
  - HDR: accepted 0xA5 → LEN. Any other accepted byte is discarded and the state stays HDR.
  - LEN: N = 0 or N > DEPTH → ERR. Otherwise latch N, clear the word counter and byte index → DATA.
  - DATA: each byte goes into byte lane [index]. On the 4th byte, write the word at the word-counter address, increment the counter, and clear the index. After word N → CSUM.
  - CSUM: accepted byte equal to the running XOR → DONE, otherwise → ERR.
  - DONE / ERR: `start` → HDR.
- The running XOR clears on entry to DATA.
- `in_ready` = 1 in HDR, LEN, DATA and CSUM; 0 in IDLE, DONE and ERR.
- `cpu_rst_n` = 1 only in DONE.
- `done` = 1 only in DONE. `error` = 1 only in ERR.
- ERR does not undo writes already made; the memory holds partial contents.
- `start` is ignored in HDR, LEN, DATA and CSUM.

## Timing
- Reset values: state IDLE, `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_rst_n` 0, `done` 0, `error` 0. Byte index, word counter and XOR are all 0.
- All outputs are registered and update on the accepting edge.
- `imem_we` is high for exactly the one cycle after the edge that accepted a word's 4th byte. `imem_addr` and `imem_wdata` are valid in that cycle, and `imem_wdata` includes that 4th byte.
- Back-to-back bytes are accepted at one per cycle with no bubbles; the last word's write completes before the checksum can be accepted.
- State changes caused by `start` take effect on the edge where `start` is sampled.
- Leaving DONE via `start`: `cpu_rst_n`/`done` drop in the same cycle that `in_ready` rises.
- `rst` low mid-frame: the block returns to reset values on that edge. Memory is untouched and no partial word is written.
- Minimum load time: 2 + 4N (+1 checksum) accepted cycles.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined: frame includes the checksum byte, and CSUM state and mismatch → ERR are present.
- `IMEM_LOADER_CSUM_EN` undefined:
  - No checksum byte and no XOR register.
  - DATA → DONE on the edge accepting the final data byte.
  - `done`/`cpu_rst_n` rise in the same cycle as the final `imem_we`.
  - ERR is reachable only via a bad length.

## Structure
- Package `imem_loader_pkg`:
  - State enum (IDLE, HDR, LEN, DATA, CSUM, DONE, ERR).
  - `HDR_BYTE` = 8'hA5.
  - 2-bit byte-lane index type.
- Sub-module `byte_packer` holds the lane index and shifts bytes into the 32-bit word. It has inputs `clk`/`rst`/`clear`/`push`/`byte` and outputs `word`/`word_valid`. The top level owns the FSM, the address counter and the checksum.

## Test plan
- Nominal load, CSUM_EN defined:
  - Stimulus: A5 02 00 00 00 00 63 D6 42 00 F7.
  - Required response: writes addr0=0x00000000 and addr1=0x0042D663, then `done`=1, `cpu_rst_n`=1, `error`=0.
- Bad checksum: the same frame ending in F6 → both words written, then `error`=1, `cpu_rst_n`=0, and `in_ready`=0.
- Length checks:
  - LEN 00 → ERR with no `imem_we`.
  - LEN 21 (33 > DEPTH) → ERR.
  - LEN 20 (32) → 32 writes to addr 0..31.
- Header hunt and stalls:
  - Stimulus: leading bytes 00 FF 5A before A5, plus random `in_valid` gaps.
  - Required response: garbage discarded, and words assemble identically to the nominal case.
- Reset mid-frame: assert `rst` low after 6 data bytes → next cycle all outputs are at reset values and no write occurs. A fresh `start` plus a full frame then loads correctly.
- Reload: from DONE, `start` → `cpu_rst_n` falls that cycle, and a second 1-word frame overwrites addr0 only.
